// File: rtl/v2_decoder_pkg.sv
// rtl/v2_decoder_pkg.sv - shared opcodes, ALU codes and control bundle for the v2 decode stage
package v2_decoder_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b01000;
    localparam logic [4:0] ALU_SLL  = 5'b00001;
    localparam logic [4:0] ALU_SRL  = 5'b00101;
    localparam logic [4:0] ALU_SRA  = 5'b01101;
    localparam logic [4:0] ALU_MUL  = 5'b10000;

    typedef enum logic [1:0] {
        A_RS1  = 2'b00,
        A_PC   = 2'b01,
        A_ZERO = 2'b10
    } alu_a_sel_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10
    } wb_sel_e;

    typedef struct packed {
        logic       branch;
        logic       jump;
        logic       jalr;
        logic       mem_rd;
        logic       mem_wr;
        logic [2:0] mem_size;
        wb_sel_e    wb_sel;
        logic [4:0] alu_ctrl;
        logic       alu_src_imm;
        alu_a_sel_e alu_a_sel;
        logic       reg_wr;
    } decode_ctrl_t;

endpackage

// File: rtl/v2_decode_logic.sv
// rtl/v2_decode_logic.sv - combinational RV32I decoder (M-extension ops when DECODER_MEXT_EN is defined)
module v2_decode_logic
    import v2_decoder_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]      instr,
    output decode_ctrl_t     ctrl,
    output logic [XLEN-1:0]  imm,
    output logic             illegal
);

    logic [6:0]   opcode;
    logic [2:0]   funct3;
    logic [6:0]   funct7;
    logic [31:0]  imm32;
    decode_ctrl_t raw;
    logic         bad;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    // Opcode decode: raw control, 32-bit immediate and the illegal flag
    always_comb begin
        raw   = '0;
        imm32 = '0;
        bad   = 1'b0;
        case (opcode)
            OP_REG: begin
                raw.reg_wr   = 1'b1;
                raw.alu_ctrl = {1'b0, instr[30], funct3};
                if (funct7 == 7'b0100000) begin
                    bad = !(funct3 == 3'b000 || funct3 == 3'b101);
                end else if (funct7 == 7'b0000001) begin
`ifdef DECODER_MEXT_EN
                    raw.alu_ctrl = {2'b10, funct3};
`else
                    bad = 1'b1;
`endif
                end else if (funct7 != 7'b0000000) begin
                    bad = 1'b1;
                end
            end
            OP_IMM: begin
                imm32           = {{20{instr[31]}}, instr[31:20]};
                raw.reg_wr      = 1'b1;
                raw.alu_src_imm = 1'b1;
                raw.alu_ctrl    = {1'b0, (funct3 == 3'b101) ? instr[30] : 1'b0, funct3};
                if (funct3 == 3'b001)
                    bad = (funct7 != 7'b0000000);
                else if (funct3 == 3'b101)
                    bad = !(funct7 == 7'b0000000 || funct7 == 7'b0100000);
            end
            OP_LOAD: begin
                imm32           = {{20{instr[31]}}, instr[31:20]};
                raw.mem_rd      = 1'b1;
                raw.mem_size    = funct3;
                raw.wb_sel      = WB_MEM;
                raw.alu_src_imm = 1'b1;
                raw.reg_wr      = 1'b1;
                bad = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            end
            OP_STORE: begin
                imm32           = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                raw.mem_wr      = 1'b1;
                raw.mem_size    = funct3;
                raw.alu_src_imm = 1'b1;
                bad = (funct3 > 3'b010);
            end
            OP_BRANCH: begin
                imm32        = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
                raw.branch   = 1'b1;
                raw.alu_ctrl = ALU_SUB;
                raw.mem_size = funct3;
                bad = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OP_JAL: begin
                imm32           = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
                raw.jump        = 1'b1;
                raw.alu_a_sel   = A_PC;
                raw.alu_src_imm = 1'b1;
                raw.wb_sel      = WB_PC4;
                raw.reg_wr      = 1'b1;
            end
            OP_JALR: begin
                imm32           = {{20{instr[31]}}, instr[31:20]};
                raw.jump        = 1'b1;
                raw.jalr        = 1'b1;
                raw.alu_src_imm = 1'b1;
                raw.wb_sel      = WB_PC4;
                raw.reg_wr      = 1'b1;
                bad = (funct3 != 3'b000);
            end
            OP_LUI: begin
                imm32           = {instr[31:12], 12'b0};
                raw.alu_a_sel   = A_ZERO;
                raw.alu_src_imm = 1'b1;
                raw.reg_wr      = 1'b1;
            end
            OP_AUIPC: begin
                imm32           = {instr[31:12], 12'b0};
                raw.alu_a_sel   = A_PC;
                raw.alu_src_imm = 1'b1;
                raw.reg_wr      = 1'b1;
            end
            default: bad = 1'b1;
        endcase
        if (instr[1:0] != 2'b11)
            bad = 1'b1;
    end

    // Illegal entries still flow, but with every side effect suppressed
    always_comb begin
        ctrl = raw;
        if (bad) begin
            ctrl.reg_wr = 1'b0;
            ctrl.mem_rd = 1'b0;
            ctrl.mem_wr = 1'b0;
            ctrl.branch = 1'b0;
            ctrl.jump   = 1'b0;
            ctrl.jalr   = 1'b0;
        end
    end

    assign illegal = bad;
    assign imm     = XLEN'($signed(imm32));

endmodule

// File: rtl/v2_decode_stage.sv
// rtl/v2_decode_stage.sv - registered RV32I decode stage with handshake, optional skid and flush (DECODER_MEXT_EN enables M ops)
module v2_decode_stage
    import v2_decoder_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SKID = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [XLEN-1:0]  out_imm,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [4:0]       out_rd,
    output decode_ctrl_t     out_ctrl,
    output logic             out_illegal
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        decode_ctrl_t    ctrl;
        logic            illegal;
    } entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_TWO   = 2'b10
    } state_t;

    state_t          state;
    entry_t          out_q;
    entry_t          skid_q;
    entry_t          new_e;
    decode_ctrl_t    dec_ctrl;
    logic [XLEN-1:0] dec_imm;
    logic            dec_illegal;
    logic            accept;
    logic            consume;

    v2_decode_logic #(.XLEN(XLEN)) u_decode (
        .instr   (in_instr),
        .ctrl    (dec_ctrl),
        .imm     (dec_imm),
        .illegal (dec_illegal)
    );

    assign new_e = '{pc: in_pc, imm: dec_imm, rs1: in_instr[19:15], rs2: in_instr[24:20],
                     rd: in_instr[11:7], ctrl: dec_ctrl, illegal: dec_illegal};

    assign out_valid = (state != ST_EMPTY);
    assign in_ready  = (SKID != 0) ? (state != ST_TWO) : (state == ST_EMPTY || out_ready);
    assign accept    = in_valid && in_ready;
    assign consume   = out_valid && out_ready;

    // Occupancy FSM; the output register always holds the oldest entry, skid the younger one
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_EMPTY;
            out_q  <= '0;
            skid_q <= '0;
        end else if (flush) begin
            state <= ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        out_q <= new_e;
                        state <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && consume) begin
                        out_q <= new_e;
                    end else if (accept) begin
                        skid_q <= new_e;
                        state  <= ST_TWO;
                    end else if (consume) begin
                        state <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (consume) begin
                        out_q <= skid_q;
                        state <= ST_ONE;
                    end
                end
                default: state <= ST_EMPTY;
            endcase
        end
    end

    assign out_pc      = out_q.pc;
    assign out_imm     = out_q.imm;
    assign out_rs1     = out_q.rs1;
    assign out_rs2     = out_q.rs2;
    assign out_rd      = out_q.rd;
    assign out_ctrl    = out_q.ctrl;
    assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_v2_decode_stage.sv
// tb/tb_v2_decode_stage.sv - directed self-checking bench for v2_decode_stage
module tb_v2_decode_stage;
    import v2_decoder_pkg::*;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_instr;
    logic [31:0]  in_pc;
    logic         flush;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_pc;
    logic [31:0]  out_imm;
    logic [4:0]   out_rs1;
    logic [4:0]   out_rs2;
    logic [4:0]   out_rd;
    decode_ctrl_t out_ctrl;
    logic         out_illegal;

    int errors = 0;
    int checks = 0;

    v2_decode_stage #(.XLEN(32), .SKID(1)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_imm     (out_imm),
        .out_rs1     (out_rs1),
        .out_rs2     (out_rs2),
        .out_rd      (out_rd),
        .out_ctrl    (out_ctrl),
        .out_illegal (out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        flush     = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_pc", out_pc, 0);
        check("rst_out_imm", out_imm, 0);
        check("rst_ctrl", out_ctrl, 0);
        reset = 1'b0;
        tick();

        // ADDI x1,x0,-1
        send(32'hFFF00093, 32'h100);
        check("addi_valid", out_valid, 1);
        check("addi_pc", out_pc, 32'h100);
        check("addi_imm", out_imm, 32'hFFFFFFFF);
        check("addi_alu", out_ctrl.alu_ctrl, 5'b00000);
        check("addi_src_imm", out_ctrl.alu_src_imm, 1);
        check("addi_reg_wr", out_ctrl.reg_wr, 1);
        check("addi_rd", out_rd, 1);
        check("addi_illegal", out_illegal, 0);

        // SRAI x2,x2,3
        send(32'h40315113, 32'h104);
        check("srai_pc", out_pc, 32'h104);
        check("srai_alu", out_ctrl.alu_ctrl, 5'b01101);
        check("srai_imm", out_imm, 32'h00000403);
        check("srai_illegal", out_illegal, 0);

        // BEQ x1,x2,-8
        send(32'hFE208CE3, 32'h108);
        check("beq_branch", out_ctrl.branch, 1);
        check("beq_imm", out_imm, 32'hFFFFFFF8);
        check("beq_alu", out_ctrl.alu_ctrl, 5'b01000);
        check("beq_reg_wr", out_ctrl.reg_wr, 0);
        check("beq_rs1", out_rs1, 1);
        check("beq_rs2", out_rs2, 2);

        // LW x5,4(x1)
        send(32'h0040A283, 32'h10C);
        check("lw_imm", out_imm, 4);
        check("lw_mem_rd", out_ctrl.mem_rd, 1);
        check("lw_size", out_ctrl.mem_size, 3'b010);
        check("lw_wb", out_ctrl.wb_sel, WB_MEM);

        // SW x5,8(x1)
        send(32'h0050A423, 32'h110);
        check("sw_imm", out_imm, 8);
        check("sw_mem_wr", out_ctrl.mem_wr, 1);
        check("sw_reg_wr", out_ctrl.reg_wr, 0);

        // LUI x7,0x12345
        send(32'h123453B7, 32'h114);
        check("lui_imm", out_imm, 32'h12345000);
        check("lui_a_sel", out_ctrl.alu_a_sel, A_ZERO);
        check("lui_rd", out_rd, 7);

        // All-zero word
        send(32'h00000000, 32'h118);
        check("zero_valid", out_valid, 1);
        check("zero_illegal", out_illegal, 1);
        check("zero_reg_wr", out_ctrl.reg_wr, 0);
        check("zero_mem_rd", out_ctrl.mem_rd, 0);

        // R funct7=0100000 with funct3=001
        send(32'h40209133, 32'h11C);
        check("r_bad_valid", out_valid, 1);
        check("r_bad_illegal", out_illegal, 1);
        check("r_bad_reg_wr", out_ctrl.reg_wr, 0);
        check("r_bad_mem_wr", out_ctrl.mem_wr, 0);
        check("r_bad_mem_rd", out_ctrl.mem_rd, 0);

        // MUL x3,x1,x2
        send(32'h022081B3, 32'h120);
`ifdef DECODER_MEXT_EN
        check("mul_alu", out_ctrl.alu_ctrl, 5'b10000);
        check("mul_illegal", out_illegal, 0);
        check("mul_reg_wr", out_ctrl.reg_wr, 1);
`else
        check("mul_illegal", out_illegal, 1);
        check("mul_reg_wr", out_ctrl.reg_wr, 0);
`endif
        tick();
        check("drain_valid", out_valid, 0);

        // Skid: three back-to-back with out_ready low
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'hFFF00093;
        in_pc     = 32'h200;
        tick();
        check("skid1_ready", in_ready, 1);
        check("skid1_pc", out_pc, 32'h200);
        in_pc = 32'h204;
        tick();
        check("skid2_ready", in_ready, 0);
        check("skid2_pc", out_pc, 32'h200);
        in_pc = 32'h208;
        tick();
        check("skid3_ready", in_ready, 0);
        check("skid3_pc", out_pc, 32'h200);
        out_ready = 1'b1;
        tick();
        check("skid_rel1_pc", out_pc, 32'h204);
        check("skid_rel1_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("skid_rel2_pc", out_pc, 32'h208);
        check("skid_rel2_valid", out_valid, 1);
        tick();
        check("skid_empty", out_valid, 0);

        // Flush while in TWO with a pending input
        out_ready = 1'b0;
        send(32'hFFF00093, 32'h300);
        send(32'hFFF00093, 32'h304);
        check("fl_two_ready", in_ready, 0);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_pc    = 32'h308;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_valid", out_valid, 0);
        check("fl_ready", in_ready, 1);
        out_ready = 1'b1;
        tick();
        check("fl_after_valid", out_valid, 0);

        // Flush from EMPTY drops the same-cycle input
        flush    = 1'b1;
        in_valid = 1'b1;
        in_pc    = 32'h30C;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_empty_valid", out_valid, 0);
        tick();
        check("fl_empty_valid2", out_valid, 0);

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        send(32'hFFF00093, 32'h400);
        check("ar_pre_valid", out_valid, 1);
        #2;
        reset = 1'b1;
        #1;
        check("ar_valid", out_valid, 0);
        check("ar_ready", in_ready, 1);
        check("ar_pc", out_pc, 0);
        #2;
        reset = 1'b0;
        tick();
        check("ar_post_valid", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/v2_decode_stage.md
Name: v2_decode_stage

Overview:
- Registered decode stage for the v2 pipelined RV32I core, between fetch and execute.
- Decodes all RV32I base opcodes: R, I, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC.
- Generates sign-extended immediates, a packed control bundle and an illegal-instruction flag.
- Valid/ready handshake on both sides, optional 2-entry skid buffer, and a flush input for branch redirect.

Parameters:
- XLEN, 32, width of pc and immediate; immediates sign-extend to XLEN; must be >= 32.
- SKID, 1, 1 = 2-entry skid buffer (in_ready depends only on registered state); 0 = single register (in_ready = !out_valid || out_ready).

Ports:
- clk  in  1  clock.
- reset  in  1  reset.
- in_valid  in  1  fetch has an instruction.
- in_ready  out  1  stage accepts in_instr/in_pc this cycle.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  pc of in_instr.
- flush  in  1  discard all held and incoming instructions.
- out_valid  out  1  decoded entry present.
- out_ready  in  1  execute consumes the entry.
- out_pc  out  XLEN  pc of the decoded entry.
- out_imm  out  XLEN  sign-extended immediate.
- out_rs1, out_rs2, out_rd  out  5 each  register indices, taken raw from instr[19:15], [24:20], [11:7].
- out_ctrl  out  decode_ctrl_t  control bundle: branch, jump, jalr, mem_rd, mem_wr, mem_size[2:0], wb_sel[1:0], alu_ctrl[4:0], alu_src_imm, alu_a_sel[1:0], reg_wr.
- out_illegal  out  1  entry is an illegal instruction.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous, active-high.
- Reset values: out_valid=0; in_ready=1; all payload outputs and the skid entry are 0.
- Latency and transfers: 1 cycle from accept (in_valid && in_ready) to out_valid. A transfer occurs on out_valid && out_ready.
- Payload stability: payload holds stable while out_valid && !out_ready.
- SKID=1: states EMPTY, ONE (output register full), TWO (output and skid full).
  - EMPTY->ONE on accept.
  - ONE->TWO on accept without consume.
  - ONE->EMPTY on consume without accept.
  - TWO->ONE on consume; the skid entry moves to the output register.
  - in_ready = (state != TWO).
  - Accept and consume in the same cycle in ONE keeps ONE and loads the new entry.
- SKID=0: same as SKID=1 without the TWO state.
- Order: entries always leave in order.
- Flush: next state is EMPTY. Same-cycle in_valid is dropped. Flush wins over accept and consume. flush is ignored while reset is high.
- Immediates:
  - I/JALR/LOAD: instr[31:20].
  - S: {[31:25],[11:7]}.
  - B: {[31],[7],[30:25],[11:8],0}.
  - J: {[31],[19:12],[20],[30:21],0}.
  - U: {[31:12],12'b0}.
  - R type: imm = 0.
- ALU control:
  - R: {0, instr[30], funct3}.
  - I: {0, instr[30] if funct3==101 else 0, funct3}.
  - LOAD/STORE/JALR/JAL/AUIPC/LUI: 00000 (add).
  - BRANCH: 01000 (sub); funct3 is passed via mem_size for the comparator.
- alu_a_sel: 00 rs1; 01 pc (AUIPC, JAL); 10 zero (LUI).
- wb_sel: 00 alu; 01 mem (LOAD); 10 pc+4 (JAL, JALR).
- reg_wr=1 for R, I, LOAD, JAL, JALR, LUI, AUIPC.
- mem_size = funct3 for LOAD/STORE.
- Illegal conditions, each setting out_illegal:
  - unknown opcode;
  - instr[1:0] != 11;
  - R funct7 not in {0000000, 0100000};
  - R funct7=0100000 with funct3 not in {000, 101};
  - I shift with imm[11:5] not 0000000, or not 0100000 for SRAI;
  - BRANCH funct3 in {010, 011};
  - LOAD funct3 in {011, 110, 111};
  - STORE funct3 > 010;
  - JALR funct3 != 000.
- Illegal handling: the entry still flows with out_illegal=1 and reg_wr, mem_rd, mem_wr, branch, jump all 0. No X is driven on any output.

Optional Feature:
- Macro: DECODER_MEXT_EN.
- Defined: R-type funct7=0000001 decodes as an M-extension op with alu_ctrl={1, 0, funct3}, reg_wr=1, out_illegal=0.
- Undefined: funct7=0000001 is illegal; alu_ctrl[4] is tied to 0.

Decomposition:
- Package v2_decoder_pkg holds:
  - opcode localparams;
  - decode_ctrl_t (packed struct);
  - alu_a_sel_e and wb_sel_e enums;
  - ALU code constants (ALU_ADD, ALU_SUB, ...).
- Sub-module v2_decode_logic: purely combinational, in_instr -> {ctrl, imm, illegal}.
- v2_decode_stage instantiates v2_decode_logic on the input side and owns the handshake and skid registers.

Test Plan:
- ADDI x1,x0,-1 (0xFFF00093), out_ready=1 -> next cycle out_valid=1, imm=0xFFFFFFFF, alu_ctrl=00000, alu_src_imm=1, reg_wr=1, rd=1, illegal=0.
- SRAI x2,x2,3 (0x40315113) -> alu_ctrl=01101, imm=0x00000403. BEQ x1,x2,-8 (0xFE208CE3) -> branch=1, imm=0xFFFFFFF8, alu_ctrl=01000, reg_wr=0.
- SKID=1, out_ready=0, three back-to-back in_valid -> first two accepted, in_ready=0 on the third. Release out_ready -> outputs emerge in order with matching out_pc; the third is accepted only after a slot frees.
- flush asserted with in_valid=1 while in state TWO -> next cycle out_valid=0, in_ready=1; no flushed pc ever appears on the output.
- 0x00000000 and R funct7=0100000 with funct3=001 -> out_illegal=1, reg_wr=0, mem_wr=0, mem_rd=0, out_valid=1.
- MUL x3,x1,x2 (0x022081B3) -> with DECODER_MEXT_EN: alu_ctrl=10000, illegal=0; without: illegal=1. Assert reset mid-stream -> out_valid=0 immediately (asynchronously).
